// File: rtl/note_sequencer.sv
// Song-pattern reader: fetches note words from a synchronous song ROM and
// hands pitch/duration/instrument to the note player, timing each note in frame strobes.
module note_sequencer #(
  parameter int SONG_ADDR_W = 8,
  parameter bit LOOP        = 1'b0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_frame_stb,
  input  logic                   i_start,
  input  logic                   i_stop,
  output logic                   o_busy,
  output logic                   o_load,
  output logic [5:0]             o_pitch,
  output logic [4:0]             o_duration,
  output logic [3:0]             o_instrument,
  output logic                   o_gate,
  output logic                   o_song_done,
  output logic [SONG_ADDR_W-1:0] o_rom_addr,
  input  logic [15:0]            i_rom_data
);

  localparam logic [15:0] END_MARKER = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_ADDR,
    S_FETCH_DATA,
    S_ISSUE,
    S_WAIT_START,
    S_HOLD
  } state_e;

  state_e                 state_q, state_d;
  logic [SONG_ADDR_W-1:0] addr_q, addr_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [5:0]             pitch_q, pitch_d;
  logic [4:0]             dur_q, dur_d;
  logic [3:0]             inst_q, inst_d;
  logic                   gate_q, gate_d;

  logic unused_rom_bit;
  assign unused_rom_bit = i_rom_data[0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      pitch_q <= '0;
      dur_q   <= '0;
      inst_q  <= '0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      pitch_q <= pitch_d;
      dur_q   <= dur_d;
      inst_q  <= inst_d;
      gate_q  <= gate_d;
    end
  end

  // NOTE: every signal gets a hold-value default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    pitch_d = pitch_q;
    dur_d   = dur_q;
    inst_d  = inst_q;
    gate_d  = gate_q;
    if (i_stop) begin
      state_d = S_IDLE;
      gate_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_start) begin
            addr_d  = '0;
            state_d = S_FETCH_ADDR;
          end
        end
        S_FETCH_ADDR: state_d = S_FETCH_DATA;
        S_FETCH_DATA: begin
          if (i_rom_data == END_MARKER) begin
            if (LOOP) begin
              addr_d  = '0;
              state_d = S_FETCH_ADDR;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            // Fields latch here so they are already valid alongside o_load in ISSUE.
            pitch_d = i_rom_data[15:10];
            dur_d   = i_rom_data[9:5];
            inst_d  = i_rom_data[4:1];
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          addr_d  = addr_q + SONG_ADDR_W'(1);
          state_d = S_WAIT_START;
        end
        S_WAIT_START: begin
          if (i_frame_stb) begin
            cnt_d = dur_q;
            if (dur_q == 5'd0) begin
              gate_d  = 1'b0;
              state_d = S_FETCH_ADDR;
            end else begin
              gate_d  = (pitch_q != 6'd0);
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (i_frame_stb) begin
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
              gate_d  = 1'b0;
              state_d = S_FETCH_ADDR;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_busy      = (state_q != S_IDLE);
    o_load      = (state_q == S_ISSUE) && (pitch_q != 6'd0);
    o_song_done = (state_q == S_FETCH_DATA) && (i_rom_data == END_MARKER);
    o_rom_addr  = (state_q == S_IDLE) ? '0 : addr_q;
  end

  assign o_pitch      = pitch_q;
  assign o_duration   = dur_q;
  assign o_instrument = inst_q;
  assign o_gate       = gate_q;

endmodule
